// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer that borrows the shared 32-bit ALU
// for every add/subtract: shift-add multiply, and restoring divide on magnitudes.
module alu_muldiv_sequencer #(
    parameter int unsigned ITERS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result
);

    localparam int unsigned CntW = $clog2(ITERS);
    localparam logic [4:0] OpAdd = 5'b00000;
    localparam logic [4:0] OpSub = 5'b00001;

    typedef enum logic [2:0] {
        StIdle,
        StNegA,
        StNegB,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            sign_q, sign_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // acc: product P / remainder R; mc: multiplicand M / divisor D;
    // mq: multiplier Q / dividend-then-quotient Qd
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     mc_q, mc_d;
    logic [31:0]     mq_q, mq_d;
    logic [31:0]     result_q, result_d;
    logic            exc_q, exc_d;

    logic [31:0]     rs;
    logic            ge;
    logic            last_iter;
    logic [31:0]     prod_next;

    assign rs        = {acc_q[30:0], mq_q[31]};
    // Unsigned Rs >= D using only the ALU's signed difference
    assign ge        = (rs[31] != mc_q[31]) ? rs[31] : ~alu_result[31];
    assign last_iter = (cnt_q == CntW'(ITERS - 1));
    assign prod_next = mq_q[0] ? alu_result : acc_q;

    always_comb begin
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_opcode   = OpAdd;
        unique case (state_q)
            StNegA: begin
                alu_opcode   = OpSub;
                alu_operandB = mq_q;
            end
            StNegB: begin
                alu_opcode   = OpSub;
                alu_operandB = mc_q;
            end
            StIter: begin
                if (is_div_q) begin
                    alu_opcode   = OpSub;
                    alu_operandA = rs;
                    alu_operandB = mc_q;
                end else begin
                    alu_opcode   = OpAdd;
                    alu_operandA = acc_q;
                    alu_operandB = mc_q;
                end
            end
            StFix: begin
                alu_opcode   = OpSub;
                alu_operandB = mq_q;
            end
            default: begin
                alu_opcode   = OpAdd;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mq_d     = mq_q;
        result_d = result_q;
        exc_d    = exc_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_MULT) begin
                    is_div_d = 1'b0;
                    acc_d    = 32'd0;
                    mc_d     = data_operandA;
                    mq_d     = data_operandB;
                    cnt_d    = '0;
                    state_d  = StIter;
                end else if (ctrl_DIV) begin
                    if (data_operandB != 32'd0) begin
                        is_div_d = 1'b1;
                        mq_d     = data_operandA;
                        mc_d     = data_operandB;
                        sign_d   = data_operandA[31] ^ data_operandB[31];
                        state_d  = StNegA;
                    end else begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StNegA: begin
                mq_d    = mq_q[31] ? alu_result : mq_q;
                acc_d   = 32'd0;
                state_d = StNegB;
            end
            StNegB: begin
                mc_d    = mc_q[31] ? alu_result : mc_q;
                cnt_d   = '0;
                state_d = StIter;
            end
            StIter: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = ge ? alu_result : rs;
                    mq_d  = {mq_q[30:0], ge};
                    if (last_iter) begin
                        state_d = StFix;
                    end
                end else begin
                    acc_d = prod_next;
                    mc_d  = {mc_q[30:0], 1'b0};
                    mq_d  = {1'b0, mq_q[31:1]};
                    if (last_iter) begin
                        result_d = prod_next;
                        exc_d    = 1'b0;
                        state_d  = StDone;
                    end
                end
            end
            StFix: begin
                result_d = sign_q ? alu_result : mq_q;
                exc_d    = 1'b0;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= 32'd0;
            mc_q     <= 32'd0;
            mq_q     <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mq_q     <= mq_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q != StIdle);
    assign alu_shiftamt   = 5'd0;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: arithmetic reference model with a per-cycle
// compare process, directed literal cases and randomized operations.
module tb_alu_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    // Shared ALU stand-in: ADD or SUB only
    assign alu_result = (alu_opcode == 5'b00001) ? alu_operandA - alu_operandB
                                                 : alu_operandA + alu_operandB;

    alu_muldiv_sequencer #(.ITERS(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
        longint q;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[31:0];
    endfunction

    // Reference model: busy/ready timing from the latency rules, results from arithmetic
    bit          m_busy, m_rdy, m_div, m_exc, p_exc;
    int          m_cnt;
    logic [31:0] m_res, p_res;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_div  <= 1'b0;
            m_exc  <= 1'b0;
            m_res  <= 32'd0;
            m_cnt  <= 0;
            p_res  <= 32'd0;
            p_exc  <= 1'b0;
        end else if (m_rdy) begin
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_rdy <= 1'b1;
                m_res <= p_res;
                m_exc <= p_exc;
            end
            m_cnt <= m_cnt - 1;
        end else if (ctrl_MULT) begin
            m_busy <= 1'b1;
            m_div  <= 1'b0;
            m_cnt  <= 32;
            p_res  <= data_operandA * data_operandB;
            p_exc  <= 1'b0;
        end else if (ctrl_DIV) begin
            m_busy <= 1'b1;
            m_div  <= 1'b1;
            if (data_operandB == 32'd0) begin
                m_rdy <= 1'b1;
                m_res <= 32'd0;
                m_exc <= 1'b1;
            end else begin
                m_cnt <= 35;
                p_res <= div_model(data_operandA, data_operandB);
                p_exc <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check32("busy", 32'(busy), 32'(m_busy));
            check32("rdy", 32'(data_resultRDY), 32'(m_rdy));
            check32("result", data_result, m_res);
            check32("exception", 32'(data_exception), 32'(m_exc));
            check32("shiftamt", 32'(alu_shiftamt), 32'd0);
            if (!m_busy || m_rdy) begin
                check32("idle_alu_a", alu_operandA, 32'd0);
                check32("idle_alu_b", alu_operandB, 32'd0);
                check32("idle_alu_op", 32'(alu_opcode), 32'd0);
            end else begin
                check32("busy_alu_op", 32'(alu_opcode), m_div ? 32'd1 : 32'd0);
            end
        end
    end

    // Issues one start, optionally injects ignored starts, returns edges to RDY
    task automatic run_op(input bit is_div, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input int div_at, input int mult_at,
                          input bit poke_done, output int lat);
        @(posedge clock);
        #1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = !is_div || both;
        ctrl_DIV  = is_div || both;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            ctrl_DIV  = (lat + 1 == div_at);
            ctrl_MULT = (lat + 1 == mult_at);
            @(posedge clock);
            #1;
            data_operandA = $urandom;
            data_operandB = $urandom;
            lat++;
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        if (lat >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no RDY within %0d edges, expected one", lat);
        end
        if (poke_done) ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
    endtask

    task automatic do_lit(input string name, input bit is_div, input bit both,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_exc, input int exp_lat,
                          input int div_at, input int mult_at);
        int lat;
        logic [31:0] res;
        logic        exc;
        @(posedge clock);
        #1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = !is_div || both;
        ctrl_DIV  = is_div || both;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            ctrl_DIV  = (lat + 1 == div_at);
            ctrl_MULT = (lat + 1 == mult_at);
            @(posedge clock);
            #1;
            lat++;
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        res = data_result;
        exc = data_exception;
        check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check32({name, "_result"}, res, exp_res);
        check32({name, "_exc"}, 32'(exc), 32'(exp_exc));
        @(posedge clock);
        #1;
        check32({name, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_lat;
        int kind;
        bit both;
        bit is_div;
        logic [31:0] a, b;
        logic [31:0] specials [6];
        specials[0] = 32'h8000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h0000_0001;
        specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0000;
        specials[5] = 32'h8000_0001;

        reset_n = 1'b0;
        chk_en  = 1'b1;
        #1;
        check32("reset_result", data_result, 32'd0);
        check32("reset_busy", 32'(busy), 32'd0);
        check32("reset_rdy", 32'(data_resultRDY), 32'd0);
        check32("reset_alu_op", 32'(alu_opcode), 32'd0);
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b1;

        do_lit("mul_7_m3", 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32, 0, 0);
        do_lit("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 35, 0, 0);
        do_lit("div_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0, 35, 0, 0);
        do_lit("div_7_m7", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 35, 0, 0);
        do_lit("div_by_zero", 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 1'b1, 0, 0, 0);
        do_lit("mul_3_4", 1'b0, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 32, 0, 0);
        do_lit("div_min_1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 35, 0, 0);
        do_lit("div_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0,
               35, 0, 0);
        do_lit("div_m1_min", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 35, 0, 0);
        do_lit("mul_ignore", 1'b0, 1'b0, 32'd5, 32'd6, 32'd30, 1'b0, 32, 10, 20);
        do_lit("both_start", 1'b0, 1'b1, 32'd9, 32'd11, 32'd99, 1'b0, 32, 0, 0);

        // Reset mid-divide: outputs must clear without waiting for a clock edge
        @(posedge clock);
        #1;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (12) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check32("async_rst_busy", 32'(busy), 32'd0);
        check32("async_rst_result", data_result, 32'd0);
        check32("async_rst_rdy", 32'(data_resultRDY), 32'd0);
        check32("async_rst_alu_op", 32'(alu_opcode), 32'd0);
        check32("async_rst_alu_a", alu_operandA, 32'd0);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        do_lit("mul_m1_m1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 32, 0, 0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            is_div = (kind >= 5);
            both = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            if (kind == 9) b = 32'd0;
            if (!is_div || both) exp_lat = 32;
            else if (b == 32'd0) exp_lat = 0;
            else exp_lat = 35;
            run_op(is_div, both, a, b, $urandom_range(0, 40), $urandom_range(0, 40),
                   ($urandom_range(0, 7) == 0), lat);
            check32("rand_latency", 32'(lat), 32'(exp_lat));
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        repeat (3) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Multi-cycle signed multiply/divide controller that reuses the processor's shared 32-bit ALU for every add/subtract.
- Holds its working registers (product, multiplicand, multiplier, remainder, quotient) and shifts them internally.
- Issues one ALU ADD or SUB per cycle.
- Sits beside the execute stage; the pipeline stalls on data_resultRDY.

Parameters:
- ITERS, 32, iteration count; equals operand width, fixed at 32.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- data_operandA  input  32  multiplicand / dividend; sampled on start
- data_operandB  input  32  multiplier / divisor; sampled on start
- ctrl_MULT  input  1  start-multiply pulse
- ctrl_DIV  input  1  start-divide pulse
- data_result  output  32  product low word or quotient
- data_exception  output  1  divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high from the start edge until the DONE cycle ends
- alu_operandA  output  32  to ALU
- alu_operandB  output  32  to ALU
- alu_opcode  output  5  ADD=5'b00000, SUB=5'b00001 only
- alu_shiftamt  output  5  constant 0
- alu_result  input  32  ALU data_result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any state, including mid-operation):
  - state=IDLE; all registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - ALU outputs ADD 0+0.
- States: IDLE, NEG_A, NEG_B, ITER, FIX, DONE.
- ALU drive is combinational from state/registers. IDLE and DONE drive ADD 0,0.
- IDLE:
  - ctrl_MULT=1: load P=0, M=A, Q=B, count=0 -> ITER(mul).
  - else ctrl_DIV=1 and B!=0: latch A, B, sign=A[31]^B[31] -> NEG_A.
  - else ctrl_DIV=1 and B==0: data_result=0, data_exception=1 -> DONE.
  - Both starts high: multiply wins; divide dropped.
- Starts while not IDLE are ignored; no queuing.
- Multiply ITER:
  - ALU ADD(P, M). P<=alu_result if Q[0], else P unchanged.
  - M<=M<<1; Q<=Q>>1 (logical).
  - After 32 iterations: data_result=P -> DONE.
  - Result is the low 32 bits of the signed product; overflow wraps silently; exception=0.
- NEG_A: ALU SUB(0, A). Store |A| (alu_result if A[31], else A) as dividend Qd; R=0.
- NEG_B: ALU SUB(0, B). Store |B| as D. count=0 -> ITER(div).
- Divide ITER (restoring, unsigned magnitudes):
  - Rs={R[30:0], Qd[31]}; ALU SUB(Rs, D).
  - Unsigned ge = (Rs[31]!=D[31]) ? Rs[31] : ~alu_result[31].
  - R<=ge ? alu_result : Rs; Qd<={Qd[30:0], ge}.
  - After 32 iterations -> FIX.
  - Rs never exceeds 32 bits because R<D<=2^31.
- FIX: ALU SUB(0, Qd). data_result=sign ? alu_result : Qd; exception=0 -> DONE.
  - Quotient truncates toward zero; remainder discarded.
  - 0x80000000 / -1 yields 0x80000000, no exception.
- DONE: data_resultRDY=1 for exactly this cycle -> IDLE. A new start is accepted only on the following IDLE cycle.
- data_result and data_exception hold until the next completion or reset.
- Latency, counted in edges after the start-sampling edge until data_resultRDY is high:
  - multiply: 32
  - divide: 35 (fixed regardless of signs)
  - divide-by-zero: 0 (RDY high in the cycle immediately after the sampling edge)
- busy=1 in NEG_A, NEG_B, ITER, FIX and DONE.

Test Plan:
- MULT A=7, B=0xFFFFFFFD -> data_result=0xFFFFFFEB, RDY pulse exactly 32 edges after start, exception=0, alu_opcode=ADD throughout ITER.
- DIV A=0xFFFFFFF9 (-7), B=2 -> data_result=0xFFFFFFFD (-3), RDY 35 edges after start; DIV 100/7 -> 14; DIV 7/-7 -> 0xFFFFFFFF.
- DIV A=0x12345678, B=0 -> RDY next cycle, data_exception=1, data_result=0; a following MULT 3*4 -> 12 with exception=0.
- DIV A=0x80000000, B=1 -> 0x80000000 (exercises the unsigned compare); A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exception=0; A=0xFFFFFFFF, B=0x80000000 -> 0.
- MULT 5*6 started; ctrl_DIV pulses at edge 10 and ctrl_MULT at edge 20 -> both ignored, single RDY with 30; ctrl_MULT and ctrl_DIV together -> multiply performed.
- Assert reset_n=0 mid-divide at edge 12 -> outputs 0 asynchronously, busy=0, no RDY; after release, MULT 0xFFFFFFFF*0xFFFFFFFF -> 1.
